// File: rtl/priority_logic.sv
// Four-channel DMA request arbiter: synchronises DREQ, picks a fixed or rotating
// priority winner, and sequences the HLDA / DACK handshake for the granted channel.
module priority_logic #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic [3:0] requestReg,
  input  logic       rotatingPriority,
  input  logic       dreqSenseLow,
  input  logic       dackSenseHigh,
  input  logic       controllerDisable,
  input  logic       HLDA,
  input  logic       assertDACK,
  input  logic       deassertDACK,
  input  logic       intEOP,
  output logic [3:0] DACK,
  output logic       anyRequest,
  output logic [1:0] activeChannel,
  output logic       channelValid,
  output logic [3:0] clearRequestBit
);

  localparam int unsigned N_CH = 4;
  localparam int unsigned CH_W = 2;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    WAIT_HLDA = 4'b0010,
    GRANTED   = 4'b0100,
    ACTIVE    = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0] sync_req, eff_req;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [N_CH-1:0] clr_q, clr_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic            valid_q, valid_d;
  logic [CH_W-1:0] base, winner, idx;
  logic            found;
  logic            release_req;

  // Polarity is applied before the first flop so the chain only ever carries "request" sense.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = DREQ ^ {N_CH{dreqSenseLow}};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_req   = sync_q[SYNC_STAGES-1];
  assign eff_req    = (sync_req & ~maskReg) | requestReg;
  assign anyRequest = (|eff_req) & ~controllerDisable;

  // Scan channels from the highest-priority one upward, wrapping modulo 4.
  always_comb begin
    base   = rotatingPriority ? last_q + CH_W'(1) : '0;
    winner = base;
    found  = 1'b0;
    idx    = base;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = base + CH_W'(i);
      if (!found && eff_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign release_req = deassertDACK | intEOP;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    last_d  = last_q;
    clr_d   = '0;

    if (controllerDisable) begin
      state_d = IDLE;
      grant_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyRequest) state_d = WAIT_HLDA;
        end
        WAIT_HLDA: begin
          if (!anyRequest) begin
            state_d = IDLE;
          end else if (HLDA) begin
            chan_d  = winner;
            valid_d = 1'b1;
            state_d = GRANTED;
          end
        end
        GRANTED: begin
          if (!HLDA) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else if (assertDACK) begin
            grant_d = N_CH'(1) << chan_q;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (release_req) begin
            grant_d = '0;
            valid_d = 1'b0;
            clr_d   = N_CH'(1) << chan_q;
            last_d  = chan_q;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sync_q  <= '0;
      grant_q <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 2'b11;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      grant_q <= grant_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      clr_q   <= clr_d;
    end
  end

  // DACK follows the registered grant only, so reset drops it without a clock edge.
  assign DACK            = dackSenseHigh ? grant_q : ~grant_q;
  assign activeChannel   = chan_q;
  assign channelValid    = valid_q;
  assign clearRequestBit = clr_q;

endmodule

// File: tb/tb_priority_logic.sv
// Directed bench for priority_logic: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_priority_logic;

  localparam int unsigned SYNC = 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_GRANT = 2, P_ACTIVE = 3;

  logic       CLK, RESET;
  logic [3:0] DREQ, maskReg, requestReg;
  logic       rotatingPriority, dreqSenseLow, dackSenseHigh, controllerDisable;
  logic       HLDA, assertDACK, deassertDACK, intEOP;
  logic [3:0] DACK, clearRequestBit;
  logic       anyRequest, channelValid;
  logic [1:0] activeChannel;

  priority_logic #(.SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg), .requestReg(requestReg),
    .rotatingPriority(rotatingPriority), .dreqSenseLow(dreqSenseLow),
    .dackSenseHigh(dackSenseHigh), .controllerDisable(controllerDisable), .HLDA(HLDA),
    .assertDACK(assertDACK), .deassertDACK(deassertDACK), .intEOP(intEOP),
    .DACK(DACK), .anyRequest(anyRequest), .activeChannel(activeChannel),
    .channelValid(channelValid), .clearRequestBit(clearRequestBit)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model state: request history, handshake phase, and the observable results.
  logic [3:0] m_hist [SYNC];
  int         m_ph;
  logic [3:0] m_dack, m_clr;
  logic [1:0] m_chan;
  int         m_last;
  logic       m_valid;

  function automatic logic [3:0] m_eff();
    return (m_hist[SYNC-1] & ~maskReg) | requestReg;
  endfunction

  function automatic logic m_any();
    return (m_eff() != 4'b0000) && !controllerDisable;
  endfunction

  function automatic int m_winner();
    int top, c;
    logic [3:0] e;
    e   = m_eff();
    top = rotatingPriority ? (m_last + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      c = (top + k) % 4;
      if (e[c]) return c;
    end
    return top;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(SYNC); i++) m_hist[i] = 4'b0000;
    m_ph = P_IDLE; m_dack = 4'b0000; m_clr = 4'b0000;
    m_chan = 2'd0; m_last = 3; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic any;
    int   w;
    if (RESET) begin
      model_reset();
      return;
    end
    any   = m_any();
    w     = m_winner();
    m_clr = 4'b0000;
    if (controllerDisable) begin
      m_ph = P_IDLE; m_dack = 4'b0000; m_valid = 1'b0;
    end else if (m_ph == P_IDLE) begin
      if (any) m_ph = P_WAIT;
    end else if (m_ph == P_WAIT) begin
      if (!any) m_ph = P_IDLE;
      else if (HLDA) begin
        m_chan = 2'(w); m_valid = 1'b1; m_ph = P_GRANT;
      end
    end else if (m_ph == P_GRANT) begin
      if (!HLDA) begin
        m_ph = P_IDLE; m_valid = 1'b0;
      end else if (assertDACK) begin
        m_dack = 4'b0000;
        m_dack[m_chan] = 1'b1;
        m_ph = P_ACTIVE;
      end
    end else begin
      if (deassertDACK || intEOP) begin
        m_clr = 4'b0000;
        m_clr[m_chan] = 1'b1;
        m_dack = 4'b0000; m_valid = 1'b0;
        m_last = int'(m_chan); m_ph = P_IDLE;
      end
    end
    for (int i = int'(SYNC) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = DREQ ^ {4{dreqSenseLow}};
  endtask

  // Compare process: mid-cycle, inputs and outputs are stable.
  always @(negedge CLK) begin
    check("dack", DACK, dackSenseHigh ? m_dack : ~m_dack);
    check("any", {3'b0, anyRequest}, {3'b0, m_any()});
    check("chan", {2'b0, activeChannel}, {2'b0, m_chan});
    check("valid", {3'b0, channelValid}, {3'b0, m_valid});
    check("clr", clearRequestBit, m_clr);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      #1;
    end
  endtask

  task automatic settle(input logic [3:0] d);
    controllerDisable = 1'b1;
    DREQ = d;
    tick(int'(SYNC) + 1);
    controllerDisable = 1'b0;
  endtask

  task automatic to_active(input logic [1:0] exp_ch);
    int k;
    k = 0;
    while (channelValid !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    check("grant_wait", {3'b0, channelValid}, 4'b0001);
    check("winner", {2'b0, activeChannel}, {2'b0, exp_ch});
    assertDACK = 1'b1;
    tick(1);
    assertDACK = 1'b0;
  endtask

  task automatic release_ch(input int mode, output logic [3:0] clr_seen);
    deassertDACK = (mode != 1);
    intEOP       = (mode != 0);
    tick(1);
    deassertDACK = 1'b0;
    intEOP       = 1'b0;
    clr_seen     = clearRequestBit;
  endtask

  task automatic serve(input logic [1:0] exp_ch, input int mode,
                       output logic [3:0] clr_seen, output logic [3:0] dack_seen);
    to_active(exp_ch);
    dack_seen = DACK;
    release_ch(mode, clr_seen);
  endtask

  logic [3:0] clr_s, dack_s;

  initial begin
    RESET = 1'b1; DREQ = '0; maskReg = '0; requestReg = '0;
    rotatingPriority = 1'b0; dreqSenseLow = 1'b0; dackSenseHigh = 1'b0;
    controllerDisable = 1'b0; HLDA = 1'b0; assertDACK = 1'b0;
    deassertDACK = 1'b0; intEOP = 1'b0;
    model_reset();
    tick(2);
    RESET = 1'b0;
    check("rst_valid", {3'b0, channelValid}, 4'b0000);
    check("rst_dack", DACK, 4'b1111);
    check("rst_clr", clearRequestBit, 4'b0000);
    tick(2);

    // Fixed priority: channels 1 and 3 request, channel 1 wins.
    HLDA = 1'b1; DREQ = 4'b1010;
    tick(4);
    check("fix_chan", {2'b0, activeChannel}, 4'b0001);
    check("fix_valid", {3'b0, channelValid}, 4'b0001);
    assertDACK = 1'b1; tick(1); assertDACK = 1'b0;
    check("fix_dack", DACK, 4'b1101);
    release_ch(0, clr_s);
    check("fix_clr", clr_s, 4'b0010);

    // Rotating priority walks 3,0,1,2 after channel 2 is served.
    rotatingPriority = 1'b1;
    settle(4'b0100);
    serve(2'd2, 0, clr_s, dack_s);
    check("rot_clr2", clr_s, 4'b0100);
    settle(4'b1111);
    serve(2'd3, 1, clr_s, dack_s);
    check("rot_clr3", clr_s, 4'b1000);
    serve(2'd0, 0, clr_s, dack_s);
    serve(2'd1, 1, clr_s, dack_s);
    serve(2'd2, 0, clr_s, dack_s);
    check("rot_dack2", dack_s, 4'b1011);

    // Mask blocks hardware request; software request is unmaskable.
    rotatingPriority = 1'b0; maskReg = 4'b0001;
    settle(4'b0001);
    #1 check("mask_any0", {3'b0, anyRequest}, 4'b0000);
    requestReg = 4'b0001;
    #1 check("sw_any1", {3'b0, anyRequest}, 4'b0001);
    serve(2'd0, 0, clr_s, dack_s);
    check("sw_clr", clr_s, 4'b0001);
    requestReg = 4'b0000; maskReg = 4'b0000;

    // Request withdrawn before HLDA: no grant.
    HLDA = 1'b0;
    settle(4'b1000);
    tick(2);
    check("wait_novalid", {3'b0, channelValid}, 4'b0000);
    DREQ = 4'b0000;
    tick(4);
    check("drop_valid", {3'b0, channelValid}, 4'b0000);
    check("drop_dack", DACK, 4'b1111);
    check("drop_any", {3'b0, anyRequest}, 4'b0000);
    HLDA = 1'b1;

    // Simultaneous deassertDACK and intEOP: one release pulse.
    settle(4'b0010);
    serve(2'd1, 2, clr_s, dack_s);
    check("both_clr", clr_s, 4'b0010);
    DREQ = 4'b0000;
    tick(1);
    check("both_clr_once", clearRequestBit, 4'b0000);
    settle(4'b0000);

    // HLDA lost while granted.
    settle(4'b0001);
    tick(2);
    check("grant_valid", {3'b0, channelValid}, 4'b0001);
    HLDA = 1'b0;
    tick(1);
    check("hlda_drop_valid", {3'b0, channelValid}, 4'b0000);
    HLDA = 1'b1;
    settle(4'b0000);

    // Inverted polarities: active-low DREQ, active-high DACK.
    dreqSenseLow = 1'b1; dackSenseHigh = 1'b1;
    settle(4'b1011);
    serve(2'd2, 0, clr_s, dack_s);
    check("pol_dack", dack_s, 4'b0100);
    settle(4'b1111);
    dreqSenseLow = 1'b0; dackSenseHigh = 1'b0;
    settle(4'b0000);

    // Asynchronous reset while active.
    rotatingPriority = 1'b1;
    settle(4'b0100);
    to_active(2'd2);
    check("pre_rst_dack", DACK, 4'b1011);
    #2 RESET = 1'b1;
    model_reset();
    #1 check("async_rst_dack", DACK, 4'b1111);
    check("async_rst_valid", {3'b0, channelValid}, 4'b0000);
    tick(1);
    RESET = 1'b0;
    settle(4'b1111);
    serve(2'd0, 0, clr_s, dack_s);
    check("rst_last_clr", clr_s, 4'b0001);
    settle(4'b0000);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_logic.md
PRIORITY_LOGIC -- requirements
Module: priority_logic

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of flops in the DREQ synchronizer (legal values 1..3).
REQ-002 SHALL have a single clock: CLK  in  1  rising-edge clock for all state.
REQ-003 SHALL have reset RESET  in  1; reset is asynchronous and active-high.
REQ-004 SHALL have DREQ  in  4  raw per-channel DMA request pins, asynchronous to CLK.
REQ-005 SHALL have maskReg  in  4  per-channel mask; 1 blocks that channel's hardware DREQ.
REQ-006 SHALL have requestReg  in  4  per-channel software request; it is not maskable.
REQ-007 SHALL have rotatingPriority  in  1  priority mode: 0 fixed, 1 rotating.
REQ-008 SHALL have dreqSenseLow  in  1  DREQ polarity: 1 means active-low.
REQ-009 SHALL have dackSenseHigh  in  1  DACK polarity: 1 means active-high.
REQ-010 SHALL have controllerDisable  in  1  holding 1 disables arbitration.
REQ-011 SHALL have HLDA  in  1  hold acknowledge from the CPU.
REQ-012 SHALL have assertDACK  in  1  single-cycle pulse from timing and control, issued in S1.
REQ-013 SHALL have deassertDACK  in  1  single-cycle pulse from timing and control at end of service.
REQ-014 SHALL have intEOP  in  1  single-cycle terminal-count or EOP pulse from timing and control.
REQ-015 SHALL have DACK  out  4  per-channel acknowledge pins, at the polarity set by dackSenseHigh.
REQ-016 SHALL have anyRequest  out  1  meaning at least one effective request is pending.
REQ-017 SHALL have activeChannel  out  2  giving the latched winning channel index.
REQ-018 SHALL have channelValid  out  1  meaning activeChannel is frozen and valid.
REQ-019 SHALL have clearRequestBit  out  4  one-hot, one-cycle pulse that clears the serviced channel's requestReg bit.

Function
REQ-020 SHALL pass each DREQ bit through a SYNC_STAGES flop synchronizer, applying polarity as syncReq = sync(DREQ XOR {4{dreqSenseLow}}).
REQ-021 SHALL form the effective request as effReq = (syncReq AND NOT maskReg) OR requestReg; anyRequest = |effReq AND NOT controllerDisable (combinational).
REQ-022 SHALL keep a 2-bit lastServiced register; the highest-priority channel is (lastServiced+1) mod 4 when rotatingPriority=1, and channel 0 when rotatingPriority=0; priority descends in ascending index, modulo 4.
REQ-023 SHALL implement FSM states IDLE, WAIT_HLDA, GRANTED, ACTIVE, encoded one-hot.
REQ-024 IDLE: go to WAIT_HLDA when anyRequest=1.
REQ-025 WAIT_HLDA: while HLDA=0 the winner is re-evaluated each cycle; on anyRequest=0 go to IDLE.
REQ-026 WAIT_HLDA: on the first cycle with HLDA=1 and anyRequest=1, latch the current winner into activeChannel, set channelValid, and go to GRANTED.
REQ-027 GRANTED: activeChannel SHALL stay frozen regardless of new requests; on assertDACK go to ACTIVE.
REQ-028 GRANTED: if HLDA drops, go to IDLE and clear channelValid.
REQ-029 ACTIVE: the one-hot DACK for activeChannel SHALL be asserted starting the cycle after assertDACK, with exactly one bit active.
REQ-030 ACTIVE: on deassertDACK or intEOP (same cycle), the next edge SHALL release DACK, clear channelValid, and pulse clearRequestBit[activeChannel] for one cycle.
REQ-031 ACTIVE: on the same edge as REQ-030, load lastServiced with activeChannel and go to IDLE.
REQ-032 SHALL treat deassertDACK and intEOP arriving together as a single release.
REQ-033 SHALL ignore assertDACK outside GRANTED and deassertDACK/intEOP outside ACTIVE.
REQ-034 controllerDisable=1 SHALL force IDLE on the next edge from any state, release DACK, clear channelValid, and emit no clearRequestBit pulse.
REQ-035 SHALL drive DACK = dackSenseHigh ? grantOneHot : NOT grantOneHot, from registered grantOneHot, with no combinational path from DREQ.
REQ-036 SHALL leave lastServiced unchanged in fixed mode except on release (REQ-030/031); a mode change takes effect for the next arbitration.

Reset
REQ-037 On RESET=1 the block SHALL immediately enter IDLE, with grantOneHot=0000, channelValid=0, activeChannel=00, clearRequestBit=0000, lastServiced=11, and synchronizer flops cleared.
REQ-038 Reset mid-ACTIVE SHALL drop DACK to inactive without waiting for a clock edge.

Verification
REQ-039 Fixed mode: DREQ=1010, HLDA=1 -> activeChannel=1; after assertDACK, DACK=1101 (dackSenseHigh=0).
REQ-040 Rotating mode: service ch2, then DREQ=1111 -> next winner ch3, then ch0, ch1, ch2.
REQ-041 maskReg=0001 with DREQ=0001 -> anyRequest=0; adding requestReg=0001 -> anyRequest=1, and release pulses clearRequestBit=0001.
REQ-042 DREQ drops in WAIT_HLDA before HLDA -> back to IDLE, DACK stays inactive, no grant.
REQ-043 Simultaneous deassertDACK and intEOP in ACTIVE -> a single clearRequestBit pulse, a single lastServiced update, return to IDLE.
REQ-044 Async RESET asserted in ACTIVE between clock edges -> DACK returns to inactive immediately and lastServiced=11.
